// File: rtl/nv_ram_rd_pkg.sv
// Shared defaults and queue entry layout for the nv_ram_rwsp read controller.
// Entries are packed as {err, data} with err in the MSB.
package nv_ram_rd_pkg;

   localparam int unsigned RD_DEPTH = 20;
   localparam int unsigned RD_AW    = 5;
   localparam int unsigned RD_DW    = 289;
   localparam int unsigned RD_QD    = 4;

   typedef struct packed {
      logic             err;
      logic [RD_DW-1:0] data;
   } rd_entry_t;

   function automatic int unsigned entry_width(int unsigned dw);
      return dw + 1;
   endfunction

   function automatic int unsigned cnt_width(int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/nv_ram_rd_skid_q.sv
// Flop-based response FIFO. Only pointers and count are reset; the data array
// is never read while count is zero, so it needs no reset.
module nv_ram_rd_skid_q
   import nv_ram_rd_pkg::*;
#(
   parameter int unsigned W  = 290,
   parameter int unsigned QD = 4,
   localparam int unsigned CW = cnt_width(QD),
   localparam int unsigned PW = (QD > 1) ? $clog2(QD) : 1
) (
   input  logic          clk,
   input  logic          nvdla_core_rstn,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic [W-1:0]  head
);

   logic [W-1:0]  mem_q [QD];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] incr(logic [PW-1:0] p);
      return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= incr(wr_ptr_q);
         if (pop)  rd_ptr_q <= incr(rd_ptr_q);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Credit gating upstream makes both of these unreachable.
   a_no_push_full: assert property (@(posedge clk) disable iff (!nvdla_core_rstn)
      !(push && count_q == CW'(QD)));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!nvdla_core_rstn)
      !(pop && count_q == '0));

endmodule

// File: rtl/nv_ram_rwsp_rd_ctrl.sv
// Read-side controller for nv_ram_rwsp RAMs: req stream -> ra/re/ore -> response FIFO.
// Define NV_RAM_RD_BYPASS_EN to present the s2 entry directly when the queue is empty.
module nv_ram_rwsp_rd_ctrl
   import nv_ram_rd_pkg::*;
#(
   parameter int unsigned DEPTH = RD_DEPTH,
   parameter int unsigned AW    = RD_AW,
   parameter int unsigned DW    = RD_DW,
   parameter int unsigned QD    = RD_QD
) (
   input  logic          clk,
   input  logic          nvdla_core_rstn,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic [AW-1:0] req_addr,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic [AW-1:0] ram_ra,
   output logic          ram_re,
   output logic          ram_ore,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   localparam int unsigned EW = entry_width(DW);
   localparam int unsigned CW = cnt_width(QD);

   logic          s1_vld_q, s1_err_q, s2_vld_q, s2_err_q;
   logic          acc, inr;
   logic [CW:0]   occ;
   logic [CW-1:0] q_cnt;
   logic [EW-1:0] q_head, push_entry;
   logic          q_push, q_pop, q_nonempty;

   // Every read in flight holds a credit, so a full pipeline always has a queue slot.
   always_comb begin
      inr        = 32'(req_addr) < DEPTH;
      occ        = {1'b0, q_cnt} + (CW + 1)'(s1_vld_q) + (CW + 1)'(s2_vld_q);
      req_rdy    = occ < (CW + 1)'(QD);
      acc        = req_vld & req_rdy;
      ram_ra     = req_addr;
      ram_re     = acc & inr;
      ram_ore    = s1_vld_q & ~s1_err_q;
      q_nonempty = q_cnt != '0;
      busy       = s1_vld_q | s2_vld_q | q_nonempty;
      push_entry = {s2_err_q, s2_err_q ? {DW{1'b0}} : ram_dout};
   end

   always_ff @(posedge clk) begin
      if (!nvdla_core_rstn) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s2_vld_q <= 1'b0;
         s2_err_q <= 1'b0;
      end else begin
         s1_vld_q <= acc;
         s1_err_q <= ~inr;
         s2_vld_q <= s1_vld_q;
         s2_err_q <= s1_err_q;
      end
   end

`ifdef NV_RAM_RD_BYPASS_EN
   logic byp;

   // A bypassed entry that is accepted this cycle must not also be queued.
   always_comb begin
      byp      = ~q_nonempty & s2_vld_q;
      rsp_vld  = q_nonempty | s2_vld_q;
      rsp_data = byp ? push_entry[DW-1:0] : q_head[DW-1:0];
      rsp_err  = byp ? s2_err_q : (q_nonempty & q_head[EW-1]);
      q_pop    = q_nonempty & rsp_rdy;
      q_push   = s2_vld_q & ~(byp & rsp_rdy);
   end
`else
   always_comb begin
      rsp_vld  = q_nonempty;
      rsp_data = q_head[DW-1:0];
      rsp_err  = q_nonempty & q_head[EW-1];
      q_pop    = q_nonempty & rsp_rdy;
      q_push   = s2_vld_q;
   end
`endif

   nv_ram_rd_skid_q #(
      .W  (EW),
      .QD (QD)
   ) u_q (
      .clk             (clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .push            (q_push),
      .push_data       (push_entry),
      .pop             (q_pop),
      .count           (q_cnt),
      .head            (q_head)
   );

endmodule

// File: tb/tb_nv_ram_rwsp_rd_ctrl.sv
// Self-checking bench for nv_ram_rwsp_rd_ctrl: vector table, directed corner
// sequences and a random run, all checked against a cycle-exact scoreboard.
module tb_nv_ram_rwsp_rd_ctrl;

   localparam int unsigned DEPTH = 20;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 289;
   localparam int unsigned QD    = 4;
`ifdef NV_RAM_RD_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic          clk = 1'b0;
   logic          nvdla_core_rstn;
   logic          req_vld, req_rdy;
   logic [AW-1:0] req_addr;
   logic          rsp_vld, rsp_rdy, rsp_err;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] ram_ra;
   logic          ram_re, ram_ore;
   logic [DW-1:0] ram_dout;
   logic          busy;

   always #5 clk = ~clk;

   nv_ram_rwsp_rd_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW),
      .QD    (QD)
   ) dut (
      .clk             (clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .req_vld         (req_vld),
      .req_rdy         (req_rdy),
      .req_addr        (req_addr),
      .rsp_vld         (rsp_vld),
      .rsp_rdy         (rsp_rdy),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .ram_ra          (ram_ra),
      .ram_re          (ram_re),
      .ram_ore         (ram_ore),
      .ram_dout        (ram_dout),
      .busy            (busy)
   );

   // RAM model: re latches the address, ore registers the data.
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] ra_lat = '0;
   logic [DW-1:0] dout_r = '0;
   assign ram_dout = dout_r;

   always @(posedge clk) begin
      if (ram_re) ra_lat <= ram_ra;
      if (ram_ore) dout_r <= (32'(ra_lat) < DEPTH) ? mem[ra_lat] : '0;
   end

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            acc_cyc;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          err;
   } vec_t;

   exp_t          sb[$];
   int            n_chk = 0, n_fail = 0;
   int            cyc = 0, n_pops = 0, n_acc = 0, last_age = 0;
   logic          exp_ore = 1'b0;
   logic [DW-1:0] last_data;
   logic          last_err;

   function automatic logic [DW-1:0] pat(int a);
      return {32'hC0DE0000 | 32'(a), 225'd0, 32'(a) * 32'h9E3779B9};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Called at negedge+1 with inputs already driven; checks, then advances one cycle.
   task automatic tick();
      logic a_inr;
      exp_t e;
      #1;
      a_inr = 32'(req_addr) < DEPTH;
      check("req_rdy", req_rdy, sb.size() < QD);
      check("busy", busy, sb.size() != 0);
      check("rsp_vld", rsp_vld, sb.size() > 0 && (cyc - sb[0].acc_cyc) >= LAT);
      check("ram_ore", ram_ore, exp_ore);
      exp_ore = 1'b0;
      if (rsp_vld && rsp_rdy && sb.size() > 0) begin
         e = sb.pop_front();
         check("rsp_data", rsp_data, e.data);
         check("rsp_err", rsp_err, e.err);
         last_data = rsp_data;
         last_err  = rsp_err;
         last_age  = cyc - e.acc_cyc;
         n_pops++;
      end
      if (req_vld && req_rdy) begin
         check("ram_re", ram_re, a_inr);
         if (a_inr) check("ram_ra", ram_ra, req_addr);
         e.data    = a_inr ? mem[req_addr] : '0;
         e.err     = !a_inr;
         e.acc_cyc = cyc;
         sb.push_back(e);
         exp_ore = a_inr;
         n_acc++;
      end else begin
         check("ram_re_idle", ram_re, 1'b0);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      nvdla_core_rstn = 1'b0;
      req_vld = 1'b0;
      rsp_rdy = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      nvdla_core_rstn = 1'b1;
      sb.delete();
      exp_ore = 1'b0;
      #1;
      check("rst_rsp_vld", rsp_vld, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_ram_ore", ram_ore, 1'b0);
      check("rst_ram_re", ram_re, 1'b0);
   endtask

   task automatic drain(input int budget);
      req_vld = 1'b0;
      rsp_rdy = 1'b1;
      for (int k = 0; k < budget && sb.size() != 0; k++) tick();
      check("drain_timeout", sb.size() == 0, 1'b1);
   endtask

   initial begin
      vec_t vt[6];
      int   p0, a0;

      for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
      mem[7] = 289'h1A5;

      vt[0] = '{addr: 5'd7,  data: 289'h1A5, err: 1'b0};
      vt[1] = '{addr: 5'd0,  data: pat(0),   err: 1'b0};
      vt[2] = '{addr: 5'd19, data: pat(19),  err: 1'b0};
      vt[3] = '{addr: 5'd20, data: '0,       err: 1'b1};
      vt[4] = '{addr: 5'd31, data: '0,       err: 1'b1};
      vt[5] = '{addr: 5'd25, data: '0,       err: 1'b1};

      nvdla_core_rstn = 1'b0;
      req_vld  = 1'b0;
      req_addr = '0;
      rsp_rdy  = 1'b0;
      @(negedge clk);
      do_reset();
      check("rst_req_rdy", req_rdy, 1'b1);

      // Single reads: data, err flag and accept-to-response latency.
      for (int i = 0; i < 6; i++) begin
         p0 = n_pops;
         req_vld  = 1'b1;
         req_addr = vt[i].addr;
         rsp_rdy  = 1'b1;
         tick();
         req_vld = 1'b0;
         for (int k = 0; k < 8 && n_pops == p0; k++) tick();
         check("tbl_seen", n_pops - p0, 1);
         check("tbl_data", last_data, vt[i].data);
         check("tbl_err", last_err, vt[i].err);
         check("tbl_latency", last_age, LAT);
      end

      // Back-to-back full sweep with no backpressure.
      p0 = n_pops;
      a0 = n_acc;
      rsp_rdy = 1'b1;
      for (int a = 0; a < 20; a++) begin
         req_vld  = 1'b1;
         req_addr = AW'(a);
         tick();
      end
      check("b2b_accepts", n_acc - a0, 20);
      drain(20);
      check("b2b_pops", n_pops - p0, 20);

      // Backpressure: credits cap accepts at QD.
      a0 = n_acc;
      p0 = n_pops;
      rsp_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         req_vld  = 1'b1;
         req_addr = AW'(i + 8);
         tick();
      end
      check("bp_accepts", n_acc - a0, QD);
      drain(20);
      check("bp_pops", n_pops - p0, QD);

      // Out-of-range request sandwiched between two valid ones.
      p0 = n_pops;
      rsp_rdy = 1'b1;
      req_vld = 1'b1;
      req_addr = 5'd3;
      tick();
      req_addr = 5'd25;
      tick();
      req_addr = 5'd4;
      tick();
      drain(20);
      check("oor_pops", n_pops - p0, 3);
      check("oor_last_data", last_data, pat(4));

      // Reset with two reads in flight and two queued.
      rsp_rdy = 1'b0;
      req_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr = AW'(i + 1);
         tick();
      end
      req_vld = 1'b0;
      check("pre_rst_busy", busy, 1'b1);
      do_reset();
      p0 = n_pops;
      rsp_rdy = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("post_rst_no_rsp", n_pops - p0, 0);
      req_vld  = 1'b1;
      req_addr = 5'd7;
      tick();
      drain(10);
      check("post_rst_data", last_data, 289'h1A5);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         req_vld  = ($urandom_range(0, 3) != 0);
         req_addr = AW'($urandom_range(0, 31));
         rsp_rdy  = ($urandom_range(0, 2) != 0);
         tick();
      end
      drain(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
